// File: rtl/nios_div_pkg.sv
// Shared types and constants for the iterative Nios divider cell.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nios_div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/nios_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the owning FSM.
module nios_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic              dvd_msb,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_nxt,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;
  logic            unused_trial_msb;

  // Trial subtract on DATA_W+1 bits; the compare decides keep vs. restore.
  // While rem < divisor holds, a kept difference always fits in DATA_W bits.
  always_comb begin
    shifted = {rem, dvd_msb};
    trial   = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    rem_nxt = q_bit ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

  assign unused_trial_msb = trial[DATA_W];

endmodule

// File: rtl/nios_div_cell.sv
// Iterative 32-bit signed/unsigned divider (div/divu) around an unsigned restoring core.
// Latency: fixed 34 cycles from the start edge to the one-cycle done pulse.
// Backpressure: start is only honoured in IDLE; anything else is dropped, busy flags the window.
module nios_div_cell
  import nios_div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M_div_start,
  input  logic              M_div_signed,
  input  logic [DATA_W-1:0] M_div_src1,
  input  logic [DATA_W-1:0] M_div_src2,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot,
  output logic [DATA_W-1:0] M_div_rem
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DIV_ITERS - 1);
  localparam logic [DIV_CNT_W-1:0] CNT_ONE  = DIV_CNT_W'(1);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DATA_W-1:0]    src1_r;
  logic [DATA_W-1:0]    src2_r;
  logic                 signed_r;
  logic [DATA_W-1:0]    rem_r;
  logic [DATA_W-1:0]    quo_r;   // dividend shifts out the top, quotient bits enter at the bottom
  logic [DATA_W-1:0]    dvs_r;
  logic                 q_neg;
  logic                 r_neg;
  logic                 div0;

  logic                 s1_neg;
  logic                 s2_neg;
  logic [DATA_W-1:0]    abs1;
  logic [DATA_W-1:0]    abs2;
  logic [DATA_W-1:0]    step_rem;
  logic                 step_q;

  // Magnitudes of the captured operands; 0x80000000 negates to itself and is used as unsigned.
  always_comb begin
    s1_neg = signed_r & src1_r[DATA_W-1];
    s2_neg = signed_r & src2_r[DATA_W-1];
    abs1   = s1_neg ? -src1_r : src1_r;
    abs2   = s2_neg ? -src2_r : src2_r;
  end

  nios_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .rem     (rem_r),
    .dvd_msb (quo_r[DATA_W-1]),
    .divisor (dvs_r),
    .rem_nxt (step_rem),
    .q_bit   (step_q)
  );

  // Control FSM with the datapath registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      src1_r     <= '0;
      src2_r     <= '0;
      signed_r   <= 1'b0;
      rem_r      <= '0;
      quo_r      <= '0;
      dvs_r      <= '0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div0       <= 1'b0;
      M_div_busy <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= '0;
      M_div_rem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (M_div_start) begin
            src1_r     <= M_div_src1;
            src2_r     <= M_div_src2;
            signed_r   <= M_div_signed;
            M_div_busy <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          rem_r <= '0;
          quo_r <= abs1;
          dvs_r <= abs2;
          q_neg <= s1_neg ^ s2_neg;
          r_neg <= s1_neg;
          div0  <= (src2_r == '0);
          cnt   <= '0;
          state <= ITER;
        end
        ITER: begin
          rem_r <= step_rem;
          quo_r <= {quo_r[DATA_W-2:0], step_q};
          cnt   <= cnt + CNT_ONE;
          if (cnt == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          // Divide by zero reports all-ones and the untouched dividend, no sign fix-up.
          if (div0) begin
            M_div_quot <= '1;
            M_div_rem  <= src1_r;
          end else begin
            M_div_quot <= q_neg ? -quo_r : quo_r;
            M_div_rem  <= r_neg ? -rem_r : rem_r;
          end
          M_div_busy <= 1'b0;
          M_div_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          M_div_done <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
